// File: rtl/xlr8_irq_resp.sv
// Core-side interrupt responder: fixed-priority arbitration over level requests,
// request/vector/taken handshake with the core sequencer, one-hot ack and XSTAT readback.
module xlr8_irq_resp #(
    parameter int WIDTH         = 8,
    parameter int VEC_W         = 5,
    parameter int VEC_BASE      = 0,
    parameter int XSTAT_Address = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       adr,
    input  logic             iore,
    output logic [7:0]       dbus_out,
    output logic             out_en,
    input  logic [WIDTH-1:0] x_irq,
    input  logic             cpu_ie,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_taken,
    input  logic             reti,
    output logic [WIDTH-1:0] x_irq_ack,
    output logic [1:0]       dbg_state
);

    localparam int         SEL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [5:0] XSTAT_ADR = 6'(XSTAT_Address);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ACK   = 2'd2,
        INSVC = 2'd3
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] low_idx;
    logic             sel_live;
    logic [7:0]       xstat;

    // Walk from the top down so the lowest set index is the one left standing.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (x_irq[i]) low_idx = SEL_W'(i);
        end
    end

    assign sel_live = |(x_irq & (WIDTH'(1) << sel));

    // Handshake: irq_req/irq_vec act as valid+payload and are held stable
    // until the core answers with a one-cycle irq_taken (the ready), or
    // until the request is withdrawn (cpu_ie low or the selected line drops);
    // taken wins over withdrawal when both happen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= '0;
            irq_req   <= 1'b0;
            irq_vec   <= '0;
            x_irq_ack <= '0;
        end else begin
            case (state)
                IDLE: begin
                    x_irq_ack <= '0;
                    if (cpu_ie && |x_irq) begin
                        sel     <= low_idx;
                        irq_req <= 1'b1;
                        irq_vec <= VEC_W'(VEC_BASE + int'(low_idx));
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (irq_taken) begin
                        irq_req   <= 1'b0;
                        irq_vec   <= '0;
                        x_irq_ack <= WIDTH'(1) << sel;
                        state     <= ACK;
                    end else if (!cpu_ie || !sel_live) begin
                        irq_req <= 1'b0;
                        irq_vec <= '0;
                        sel     <= '0;
                        state   <= IDLE;
                    end
                end
                ACK: begin
                    x_irq_ack <= '0;
                    state     <= INSVC;
                end
                INSVC: begin
                    // sel is cleared on the way out so XSTAT reads zero when idle.
                    if (reti) begin
                        sel   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign xstat     = {(state == ACK) || (state == INSVC), (state == REQ), 3'b000, 3'(sel)};
    assign out_en    = iore && (adr == XSTAT_ADR);
    assign dbus_out  = out_en ? xstat : 8'h00;
    assign dbg_state = state;

endmodule

// File: tb/tb_xlr8_irq_resp.sv
// Bench for xlr8_irq_resp: directed vector table, a narrow/wrapping instance,
// and randomized traffic checked against a behavioural model with an ack scoreboard.
module tb_xlr8_irq_resp;

    localparam logic [5:0] XADR = 6'h25;

    logic       clk;
    logic       rst;
    logic [5:0] adr;
    logic       iore;
    logic [7:0] x_irq;
    logic       cpu_ie, irq_taken, reti;
    logic [7:0] dbus_out;
    logic       out_en, irq_req;
    logic [4:0] irq_vec;
    logic [7:0] x_irq_ack;
    logic [1:0] dbg_state;

    logic [3:0] x_irq4;
    logic       cpu_ie4, irq_taken4, reti4;
    logic [7:0] dbus_out4;
    logic       out_en4, irq_req4;
    logic [4:0] irq_vec4;
    logic [3:0] x_irq_ack4;
    logic [1:0] dbg_state4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    xlr8_irq_resp #(.WIDTH(8), .VEC_W(5), .VEC_BASE(3), .XSTAT_Address(37)) u_dut (
        .clk(clk), .rst(rst), .adr(adr), .iore(iore), .dbus_out(dbus_out), .out_en(out_en),
        .x_irq(x_irq), .cpu_ie(cpu_ie), .irq_req(irq_req), .irq_vec(irq_vec),
        .irq_taken(irq_taken), .reti(reti), .x_irq_ack(x_irq_ack), .dbg_state(dbg_state)
    );

    xlr8_irq_resp #(.WIDTH(4), .VEC_W(5), .VEC_BASE(30), .XSTAT_Address(0)) u_dut4 (
        .clk(clk), .rst(rst), .adr(adr), .iore(iore), .dbus_out(dbus_out4), .out_en(out_en4),
        .x_irq(x_irq4), .cpu_ie(cpu_ie4), .irq_req(irq_req4), .irq_vec(irq_vec4),
        .irq_taken(irq_taken4), .reti(reti4), .x_irq_ack(x_irq_ack4), .dbg_state(dbg_state4)
    );

    typedef struct {
        logic       rst;
        logic [7:0] x;
        logic       ie, tk, rt, rd;
        logic [5:0] a;
        logic       req;
        logic [4:0] vec;
        logic [7:0] ack;
        logic       oen;
        logic [7:0] dbus;
    } vec_t;

    vec_t tbl[$];

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] x, input logic ie, input logic tk,
                       input logic rt, input logic rd, input logic [5:0] a, input logic req,
                       input logic [4:0] vec, input logic [7:0] ack, input logic oen,
                       input logic [7:0] dbus);
        vec_t v;
        v.rst = r; v.x = x; v.ie = ie; v.tk = tk; v.rt = rt; v.rd = rd; v.a = a;
        v.req = req; v.vec = vec; v.ack = ack; v.oen = oen; v.dbus = dbus;
        tbl.push_back(v);
    endtask

    // behavioural reference model
    logic m_pend, m_ack, m_svc;
    int   m_sel;

    task automatic model_edge();
        if (rst) begin
            m_pend = 0; m_ack = 0; m_svc = 0; m_sel = 0;
        end else if (m_pend) begin
            if (irq_taken) begin
                m_pend = 0; m_ack = 1;
            end else if (!cpu_ie || !x_irq[m_sel]) begin
                m_pend = 0; m_sel = 0;
            end
        end else if (m_ack) begin
            m_ack = 0; m_svc = 1;
        end else if (m_svc) begin
            if (reti) begin
                m_svc = 0; m_sel = 0;
            end
        end else if (cpu_ie && x_irq != 0) begin
            for (int i = 7; i >= 0; i--) if (x_irq[i]) m_sel = i;
            m_pend = 1;
        end
    endtask

    initial begin
        logic [7:0] e_ack, e_dbus, got;
        logic       e_oen;
        rst = 1; adr = XADR; iore = 0; x_irq = 0; cpu_ie = 0; irq_taken = 0; reti = 0;
        x_irq4 = 0; cpu_ie4 = 0; irq_taken4 = 0; reti4 = 0;
        m_pend = 0; m_ack = 0; m_svc = 0; m_sel = 0;

        //   rst  x      ie tk rt rd adr   req vec ack    oen dbus
        add(1, 8'h00, 0, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h00, 1, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h04, 1, 0, 0, 1, XADR, 1, 5, 8'h00, 1, 8'h42);
        add(0, 8'h04, 1, 0, 0, 1, XADR, 1, 5, 8'h00, 1, 8'h42);
        add(0, 8'h04, 1, 1, 0, 1, XADR, 0, 0, 8'h04, 1, 8'h82);
        add(0, 8'h00, 1, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h82);
        add(0, 8'h01, 1, 1, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h82);
        add(0, 8'h00, 1, 0, 1, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h30, 1, 0, 0, 1, 6'h10, 1, 7, 8'h00, 0, 8'h00);
        add(0, 8'h32, 1, 0, 0, 1, XADR, 1, 7, 8'h00, 1, 8'h44);
        add(0, 8'h32, 1, 1, 0, 1, XADR, 0, 0, 8'h10, 1, 8'h84);
        add(0, 8'h22, 1, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h84);
        add(0, 8'h22, 1, 0, 1, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h22, 1, 0, 0, 1, XADR, 1, 4, 8'h00, 1, 8'h41);
        add(0, 8'h22, 0, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h22, 1, 0, 0, 1, XADR, 1, 4, 8'h00, 1, 8'h41);
        add(0, 8'h22, 0, 1, 0, 1, XADR, 0, 0, 8'h02, 1, 8'h81);
        add(0, 8'h20, 0, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h81);
        add(1, 8'h20, 0, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h00, 1, 0, 1, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h08, 1, 0, 0, 1, XADR, 1, 6, 8'h00, 1, 8'h43);
        add(1, 8'h08, 1, 0, 0, 1, XADR, 0, 0, 8'h00, 1, 8'h00);
        add(0, 8'h00, 1, 1, 0, 0, XADR, 0, 0, 8'h00, 0, 8'h00);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; x_irq = tbl[i].x; cpu_ie = tbl[i].ie; irq_taken = tbl[i].tk;
            reti = tbl[i].rt; iore = tbl[i].rd; adr = tbl[i].a;
            step();
            check($sformatf("tbl%0d_req", i), 32'(irq_req), 32'(tbl[i].req));
            check($sformatf("tbl%0d_vec", i), 32'(irq_vec), 32'(tbl[i].vec));
            check($sformatf("tbl%0d_ack", i), 32'(x_irq_ack), 32'(tbl[i].ack));
            check($sformatf("tbl%0d_oen", i), 32'(out_en), 32'(tbl[i].oen));
            check($sformatf("tbl%0d_dbus", i), 32'(dbus_out), 32'(tbl[i].dbus));
        end

        // narrow instance: vector number wraps, ack confined to WIDTH bits
        rst = 1; x_irq = 0; irq_taken = 0; reti = 0; adr = 6'h00; iore = 1;
        step();
        rst = 0; x_irq4 = 4'h8; cpu_ie4 = 1;
        step();
        check("w4_req", 32'(irq_req4), 32'd1);
        check("w4_vec", 32'(irq_vec4), 32'd1);
        check("w4_xstat_req", 32'(dbus_out4), 32'h43);
        irq_taken4 = 1;
        step();
        check("w4_ack", 32'(x_irq_ack4), 32'h8);
        check("w4_req_off", 32'(irq_req4), 32'd0);
        irq_taken4 = 0; x_irq4 = 4'h0;
        step();
        check("w4_ack_once", 32'(x_irq_ack4), 32'h0);
        check("w4_xstat_svc", 32'(dbus_out4), 32'h83);
        reti4 = 1;
        step();
        reti4 = 0; cpu_ie4 = 0;
        check("w4_xstat_idle", 32'(dbus_out4), 32'h00);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst = (c == 0) || ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) x_irq = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 7) == 0) x_irq = 8'h00;
            cpu_ie    = ($urandom_range(0, 3) != 0);
            irq_taken = ($urandom_range(0, 2) == 0);
            reti      = ($urandom_range(0, 3) == 0);
            iore      = 1'($urandom_range(0, 1));
            adr       = ($urandom_range(0, 1) == 1) ? XADR : 6'($urandom_range(0, 63));
            model_edge();
            e_ack  = m_ack ? (8'h01 << m_sel) : 8'h00;
            e_oen  = iore && (adr == XADR);
            e_dbus = e_oen ? 8'((m_ack || m_svc) * 128 + m_pend * 64 + m_sel) : 8'h00;
            if (m_ack) exp_q.push_back(e_ack);
            step();
            check($sformatf("rnd%0d_req", c), 32'(irq_req), 32'(m_pend));
            check($sformatf("rnd%0d_vec", c), 32'(irq_vec), m_pend ? 32'((3 + m_sel) % 32) : 32'd0);
            check($sformatf("rnd%0d_oen", c), 32'(out_en), 32'(e_oen));
            check($sformatf("rnd%0d_dbus", c), 32'(dbus_out), 32'(e_dbus));
            if (x_irq_ack != 8'h00) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("rnd%0d_ack_unexpected", c), 32'(x_irq_ack), 32'h0);
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("rnd%0d_ack", c), 32'(x_irq_ack), 32'(got));
                end
            end
            x_irq = x_irq & ~e_ack;
        end
        check("ack_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
